// File: rtl/edc_seq_pkg.sv
// Shared definitions for the frame sequencer: state encoding and default depth.
package edc_seq_pkg;

  localparam int NDATA_DEF = 128;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Request/response bundle between a frame requester and the frame sequencer.
interface frame_sequencer_if #(parameter int NDATA = edc_seq_pkg::NDATA_DEF);

  localparam int NDATA_LOG = $clog2(NDATA);

  logic                 start;
  logic [NDATA_LOG-1:0] len_m1;
  logic                 stall;
  logic                 abort;
  logic                 busy;
  logic                 addr_vld;
  logic [NDATA_LOG-1:0] addr;
  logic                 last;
  logic                 done;

  modport master (
    output start, len_m1, stall, abort,
    input  busy, addr_vld, addr, last, done
  );

  modport slave (
    input  start, len_m1, stall, abort,
    output busy, addr_vld, addr, last, done
  );

endinterface

// File: rtl/seq_counter.sv
// Word address counter with synchronous clear and increment enable.
module seq_counter #(
  parameter int NDATA = edc_seq_pkg::NDATA_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(NDATA)-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else if (clr) begin
      dout <= '0;
    end else if (inc) begin
      dout <= dout + 1'b1;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Issues one word address per unstalled cycle for a frame of len_m1+1 words.
//   state | meaning
//   IDLE  | waiting for start; length latched and counter cleared on accept
//   RUN   | addr_vld high, address advances unless stalled
//   DONE  | single-cycle completion pulse
module frame_sequencer
  import edc_seq_pkg::*;
#(
  parameter int NDATA = NDATA_DEF
) (
  input  logic               clk,
  input  logic               rst,
  frame_sequencer_if.slave   bus
);

  localparam int NDATA_LOG = $clog2(NDATA);

  state_t               state;
  state_t               state_nxt;
  logic [NDATA_LOG-1:0] len_q;
  logic [NDATA_LOG-1:0] addr;
  logic                 clr;
  logic                 inc;
  logic                 at_end;

  assign at_end = (addr == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
    end else if (clr) begin
      len_q <= bus.len_m1;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if (!bus.abort) begin
      case (state)
        IDLE:    state_nxt = bus.start ? RUN : IDLE;
        RUN:     state_nxt = (!bus.stall && at_end) ? DONE : RUN;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; clr/inc are internal strobes.
  always_comb begin
    clr          = (state == IDLE) && bus.start && !bus.abort;
    inc          = (state == RUN) && !bus.stall && !bus.abort && !at_end;
    bus.busy     = (state == RUN) || (state == DONE);
    bus.addr_vld = (state == RUN);
    bus.last     = (state == RUN) && at_end;
    bus.done     = (state == DONE);
    bus.addr     = addr;
  end

  seq_counter #(.NDATA(NDATA)) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (inc),
    .dout (addr)
  );

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter NDATA, default 128, giving the address-space depth in words.
REQ-002 SHALL have localparam NDATA_LOG = $clog2(NDATA), giving the address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: frame request, sampled only in IDLE.
REQ-006 SHALL have port len_m1, input, NDATA_LOG bits: frame length minus one, sampled with start.
REQ-007 SHALL have port stall, input, 1 bit: active-high downstream hold; the address is frozen while high.
REQ-008 SHALL have port abort, input, 1 bit: active-high frame cancel.
REQ-009 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-010 SHALL have port addr_vld, output, 1 bit: high in RUN only.
REQ-011 SHALL have port addr, output, NDATA_LOG bits: current word address.
REQ-012 SHALL have port last, output, 1 bit: high when addr_vld=1 and addr==len_m1 (latched copy).
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE, all registered.
REQ-015 In IDLE, start=1 and abort=0 SHALL latch len_m1, clear addr to 0, and move to RUN on the next edge; addr_vld therefore rises 1 cycle after start is sampled.
REQ-016 In RUN with stall=0 and addr!=len_m1, addr SHALL increment by 1 each cycle.
REQ-017 In RUN with stall=1, addr, addr_vld and last SHALL hold unchanged; there is no stall limit.
REQ-018 In RUN with stall=0 and addr==len_m1, the next state SHALL be DONE, and addr SHALL hold its final value.
REQ-019 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE; stall is ignored in DONE.
REQ-020 start SHALL be ignored in RUN and DONE; it is not queued. Minimum start-to-start spacing is len_m1+3 cycles with no stall.
REQ-021 Changes to len_m1 after acceptance SHALL have no effect on the running frame.
REQ-022 len_m1=0 SHALL produce exactly one address (0), with last=1 in that cycle.
REQ-023 len_m1=NDATA-1 SHALL produce addresses 0..NDATA-1; addr never wraps within a frame.
REQ-024 abort=1 in any state SHALL force IDLE on the next edge, with no done pulse.
REQ-025 abort SHALL take priority over start, stall and terminal count.
REQ-026 abort=1 together with start=1 in IDLE SHALL leave the block in IDLE.
REQ-027 The number of addresses issued with addr_vld=1 and stall=0 SHALL equal len_m1+1 for every non-aborted frame.

Reset
REQ-028 rst=0 SHALL asynchronously force state=IDLE, addr=0, the latched length=0, busy=0, addr_vld=0, last=0 and done=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame with no done pulse.
REQ-030 The first start SHALL be accepted on the first rising edge after rst deasserts.
REQ-031 All outputs SHALL be driven directly from registers or from a decode of registered state only; no input-to-output combinational path.

Structure
REQ-032 The package edc_seq_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default NDATA.
REQ-033 The address counter SHALL be a sub-module, seq_counter, with ports clk, rst, clr (synchronous, active-high), inc (active-high) and dout[NDATA_LOG-1:0].
REQ-034 The FSM SHALL live in frame_sequencer and drive seq_counter's clr and inc.
REQ-035 Unused state encoding 2'b11 SHALL recover to IDLE on the next edge.

Verification (NDATA=128)
REQ-036 Stimulus: start with len_m1=3, no stall. Response: addr 0,1,2,3 on 4 consecutive cycles; last only on 3; done 1 cycle later; busy low the cycle after done.
REQ-037 Stimulus: len_m1=5, stall high for 2 cycles while addr=2. Response: addr=2 held 3 cycles, total 6 valid addresses, done after addr 5.
REQ-038 Stimulus: len_m1=0, then len_m1=127. Response: a single addr 0 with last=1; then addresses 0..127 with no wrap, done after 127.
REQ-039 Stimulus: abort at addr=4 of a len_m1=9 frame. Response: IDLE next cycle, addr_vld=0, no done pulse; a start the following cycle is accepted.
REQ-040 Stimulus: start held high continuously with len_m1=1. Response: frames begin every 4 cycles; a start seen during RUN or DONE is never queued.
REQ-041 Stimulus: rst pulsed low mid-frame, asynchronous to clk. Response: all outputs 0 immediately; no done; a normal frame runs after release.
